// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the nqcpu load/store stage
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] LANE_LO = 2'b01;
  localparam logic [1:0] LANE_HI = 2'b10;
  localparam logic [1:0] LANE_W  = 2'b11;

  localparam int MAX_WAIT_DEF = 255;

endpackage

// File: rtl/mem_lane.sv
// rtl/mem_lane.sv - byte-lane steering for bus writes and load-data extraction
module mem_lane
  import mem_pkg::*;
(
  input  logic        byte_op,
  input  logic        addr_lsb,
  input  logic [15:0] wdata,
  input  logic [15:0] rdata,
  output logic [1:0]  be,
  output logic [15:0] bus_wdata,
  output logic [15:0] load_data
);

  always_comb begin
    be        = LANE_W;
    bus_wdata = wdata;
    load_data = rdata;
    if (byte_op) begin
      be        = addr_lsb ? LANE_HI : LANE_LO;
      // Byte stores replicate onto both lanes; the enables pick the real one.
      bus_wdata = {wdata[7:0], wdata[7:0]};
      load_data = {8'h00, (addr_lsb ? rdata[15:8] : rdata[7:0])};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - load/store stage: runs one memory op on the 16-bit bus
module mem_stage
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        op_load_i,
  input  logic        op_store_i,
  input  logic        op_byte_i,
  input  logic [15:0] op_addr_i,
  input  logic [15:0] op_wdata_i,
  input  logic [2:0]  op_dest_i,
  input  logic        needWait_i,
  input  logic [15:0] data_i,
  output logic [15:0] addr_o,
  output logic        re_o,
  output logic        we_o,
  output logic [1:0]  be_o,
  output logic [15:0] data_o,
  output logic        rf_we,
  output logic [2:0]  rf_regDest,
  output logic [15:0] rf_dataIn,
  output logic        rf_hb,
  output logic        rf_lb,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  state_t              state, state_n;
  logic                is_load_q, is_store_q, byte_q, err_q;
  logic [15:0]         addr_q, wdata_q, rdata_q;
  logic [2:0]          dest_q;
  logic [WAIT_W-1:0]   wait_cnt;

  logic                has_op, misalign, go_access, timeout;
  logic [1:0]          lane_be;
  logic [15:0]         lane_wdata, lane_load;

  assign has_op    = op_load_i | op_store_i;
  assign misalign  = ~op_byte_i & op_addr_i[0];
  assign go_access = start_i & has_op & ~misalign;
  assign timeout   = needWait_i && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  mem_lane u_lane (
    .byte_op   (byte_q),
    .addr_lsb  (addr_q[0]),
    .wdata     (wdata_q),
    .rdata     (rdata_q),
    .be        (lane_be),
    .bus_wdata (lane_wdata),
    .load_data (lane_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      byte_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      dest_q     <= '0;
      wait_cnt   <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            is_load_q  <= op_load_i;
            is_store_q <= op_store_i & ~op_load_i;
            err_q      <= has_op & misalign;
            dest_q     <= op_dest_i;
            wait_cnt   <= '0;
            // Bus-facing registers only move when a bus cycle really starts.
            if (go_access) begin
              addr_q  <= op_addr_i;
              wdata_q <= op_wdata_i;
              byte_q  <= op_byte_i;
            end
          end
        end
        ST_ACCESS: begin
          if (needWait_i) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            if (timeout) err_q <= 1'b1;
          end else if (is_load_q) begin
            rdata_q <= data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (start_i) state_n = go_access ? ST_ACCESS : ST_DONE;
      ST_ACCESS: if (!needWait_i || timeout) state_n = ST_DONE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  assign addr_o     = {addr_q[15:1], 1'b0};
  assign data_o     = lane_wdata;
  assign re_o       = (state == ST_ACCESS) & is_load_q;
  assign we_o       = (state == ST_ACCESS) & is_store_q;
  assign be_o       = (state == ST_ACCESS) ? lane_be : 2'b00;
  assign busy_o     = (state != ST_IDLE);
  assign done_o     = (state == ST_DONE);
  assign err_o      = done_o & err_q;
  assign rf_we      = done_o & is_load_q & ~err_q;
  assign rf_lb      = rf_we;
  assign rf_hb      = rf_we & ~byte_q;
  assign rf_regDest = dest_q;
  assign rf_dataIn  = lane_load;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, op_load_i = 1'b0, op_store_i = 1'b0, op_byte_i = 1'b0;
  logic [15:0] op_addr_i = '0, op_wdata_i = '0, data_i = '0;
  logic [2:0]  op_dest_i = '0;
  logic        needWait_i = 1'b0;
  logic [15:0] addr_o, data_o, rf_dataIn;
  logic        re_o, we_o, rf_we, rf_hb, rf_lb, busy_o, done_o, err_o;
  logic [1:0]  be_o;
  logic [2:0]  rf_regDest;

  typedef struct packed {
    logic [15:0] addr;
    logic        re;
    logic        we;
    logic [1:0]  be;
    logic [15:0] data;
  } bus_t;

  typedef struct packed {
    logic        err;
    logic        we;
    logic [2:0]  dest;
    logic [15:0] data;
    logic        hb;
    logic        lb;
    logic [31:0] cyc;
  } resp_t;

  bus_t  bus_q[$];
  resp_t resp_q[$];
  bus_t  b;
  resp_t r;
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_stage #(.MAX_WAIT(4), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_load_i(op_load_i),
    .op_store_i(op_store_i), .op_byte_i(op_byte_i), .op_addr_i(op_addr_i),
    .op_wdata_i(op_wdata_i), .op_dest_i(op_dest_i), .needWait_i(needWait_i),
    .data_i(data_i), .addr_o(addr_o), .re_o(re_o), .we_o(we_o), .be_o(be_o),
    .data_o(data_o), .rf_we(rf_we), .rf_regDest(rf_regDest), .rf_dataIn(rf_dataIn),
    .rf_hb(rf_hb), .rf_lb(rf_lb), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (re_o || we_o) begin
        if (bus_q.size() == 0) check("bus_unexpected", {30'd0, re_o, we_o}, 32'd0);
        else begin
          b = bus_q.pop_front();
          check("addr_o", addr_o, b.addr);
          check("re_o", re_o, b.re);
          check("we_o", we_o, b.we);
          check("be_o", be_o, b.be);
          if (b.we) check("data_o", data_o, b.data);
        end
      end
      if (done_o) begin
        if (resp_q.size() == 0) check("done_unexpected", done_o, 1'b0);
        else begin
          r = resp_q.pop_front();
          check("done_cycle", cyc, r.cyc);
          check("err_o", err_o, r.err);
          check("rf_we", rf_we, r.we);
          if (r.we) begin
            check("rf_regDest", rf_regDest, r.dest);
            check("rf_dataIn", rf_dataIn, r.data);
          end
          check("rf_hb", rf_hb, r.hb);
          check("rf_lb", rf_lb, r.lb);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", busy_o, 1'b0);
  endtask

  task automatic do_op(input logic ld, input logic st, input logic by,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [2:0] dest, input logic [15:0] rdata,
                       input int waits, input int nbus, input bus_t eb,
                       input resp_t er, input int off);
    @(posedge clk); #1;
    for (int i = 0; i < nbus; i++) bus_q.push_back(eb);
    er.cyc = cyc + off;
    resp_q.push_back(er);
    op_load_i = ld; op_store_i = st; op_byte_i = by;
    op_addr_i = addr; op_wdata_i = wdata; op_dest_i = dest; data_i = rdata;
    needWait_i = (waits > 0);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    if (waits > 0) begin
      repeat (waits) @(posedge clk);
      #1 needWait_i = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 1'b0);
    check("rst_strobes", {re_o, we_o, be_o}, 4'b0);
    check("rst_done", {done_o, err_o}, 2'b0);
    check("rst_rf", {rf_we, rf_hb, rf_lb, rf_regDest}, 6'b0);
    check("rst_addr_data", {addr_o, data_o}, 32'd0);
    check("rst_rf_data", rf_dataIn, 16'h0);
    rst = 1'b0;

    // word load, no wait
    do_op(1, 0, 0, 16'h0010, 16'h0000, 3'd3, 16'hBEEF, 0, 1,
          bus_t'{16'h0010, 1'b1, 1'b0, 2'b11, 16'h0},
          resp_t'{1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b1, 1'b1, 32'd0}, 2);
    // byte store, odd address, three wait cycles
    do_op(0, 1, 1, 16'h0021, 16'h12A5, 3'd0, 16'h0000, 3, 4,
          bus_t'{16'h0020, 1'b0, 1'b1, 2'b10, 16'hA5A5},
          resp_t'{1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 32'd0}, 5);
    // byte load, high lane
    do_op(1, 0, 1, 16'h0031, 16'h0000, 3'd5, 16'h7F40, 0, 1,
          bus_t'{16'h0030, 1'b1, 1'b0, 2'b10, 16'h0},
          resp_t'{1'b0, 1'b1, 3'd5, 16'h007F, 1'b0, 1'b1, 32'd0}, 2);
    // byte load, low lane
    do_op(1, 0, 1, 16'h0030, 16'h0000, 3'd2, 16'h7F40, 0, 1,
          bus_t'{16'h0030, 1'b1, 1'b0, 2'b01, 16'h0},
          resp_t'{1'b0, 1'b1, 3'd2, 16'h0040, 1'b0, 1'b1, 32'd0}, 2);
    // misaligned word store: no bus cycle, error
    do_op(0, 1, 0, 16'h0041, 16'h1111, 3'd0, 16'h0000, 0, 0,
          bus_t'{16'h0, 1'b0, 1'b0, 2'b00, 16'h0},
          resp_t'{1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 32'd0}, 1);
    check("addr_hold_after_misalign", addr_o, 16'h0030);
    // word store with one wait
    do_op(0, 1, 0, 16'h0050, 16'h1234, 3'd0, 16'h0000, 1, 2,
          bus_t'{16'h0050, 1'b0, 1'b1, 2'b11, 16'h1234},
          resp_t'{1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 32'd0}, 3);
    // neither load nor store
    do_op(0, 0, 0, 16'h0060, 16'h0000, 3'd1, 16'h0000, 0, 0,
          bus_t'{16'h0, 1'b0, 1'b0, 2'b00, 16'h0},
          resp_t'{1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 32'd0}, 1);
    // load and store both set: load wins
    do_op(1, 1, 0, 16'h0062, 16'h0000, 3'd6, 16'hCAFE, 0, 1,
          bus_t'{16'h0062, 1'b1, 1'b0, 2'b11, 16'h0},
          resp_t'{1'b0, 1'b1, 3'd6, 16'hCAFE, 1'b1, 1'b1, 32'd0}, 2);
    // byte store, even address
    do_op(0, 1, 1, 16'h0104, 16'h00C3, 3'd0, 16'h0000, 0, 1,
          bus_t'{16'h0104, 1'b0, 1'b1, 2'b01, 16'hC3C3},
          resp_t'{1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 32'd0}, 2);

    // timeout with needWait stuck high; second start mid-access is ignored
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) bus_q.push_back(bus_t'{16'h0080, 1'b1, 1'b0, 2'b11, 16'h0});
    resp_q.push_back(resp_t'{1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, cyc + 5});
    op_load_i = 1; op_store_i = 0; op_byte_i = 0; op_addr_i = 16'h0080;
    op_dest_i = 3'd4; data_i = 16'h9999; needWait_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    @(posedge clk); #1 start_i = 1'b1; op_addr_i = 16'h0090;
    @(posedge clk); #1 start_i = 1'b0;
    wait_idle();
    needWait_i = 1'b0;
    @(posedge clk); #1;
    check("ignored_start", busy_o, 1'b0);

    // asynchronous reset during ACCESS
    @(posedge clk); #1;
    op_load_i = 1; op_store_i = 0; op_byte_i = 0; op_addr_i = 16'h0070;
    needWait_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    check("re_before_rst", re_o, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_re", re_o, 1'b0);
    check("rst_async_busy", busy_o, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    needWait_i = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst", busy_o, 1'b0);
    do_op(1, 0, 0, 16'h0070, 16'h0000, 3'd7, 16'h5A5A, 0, 1,
          bus_t'{16'h0070, 1'b1, 1'b0, 2'b11, 16'h0},
          resp_t'{1'b0, 1'b1, 3'd7, 16'h5A5A, 1'b1, 1'b1, 32'd0}, 2);

    repeat (2) @(posedge clk);
    #1;
    check("bus_q_drained", bus_q.size(), 32'd0);
    check("resp_q_drained", resp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Load/store stage directly downstream of the ALU stage in nqcpu.
- Accepts a resolved memory operation (effective address, store data, destination register, width) and runs it on the shared 16-bit bus with a needWait_i stall handshake.
- For loads, produces a register-file write with byte-lane enables.
- Exports busy_o so the control unit stalls fetch and bus ownership while an access is in flight.

Parameters:
- MAX_WAIT, 255: wait-stall cycles tolerated in ACCESS before the access is aborted with err_o. Must be at least 1.
- WAIT_W, 8: width of the wait counter. Must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk, input, 1: clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start_i, input, 1: single-cycle request strobe from the ALU stage; sampled only in IDLE.
- op_load_i, input, 1: request is a load.
- op_store_i, input, 1: request is a store. If both op_load_i and op_store_i are high, load wins.
- op_byte_i, input, 1: byte access; word access when 0.
- op_addr_i, input, 16: effective byte address.
- op_wdata_i, input, 16: store data; for byte stores only [7:0] is used.
- op_dest_i, input, 3: load destination register.
- needWait_i, input, 1: memory not ready; extends ACCESS.
- data_i, input, 16: read data from the bus.
- addr_o, output, 16: word-aligned bus address.
- re_o, output, 1: bus read strobe.
- we_o, output, 1: bus write strobe.
- be_o, output, 2: byte enables; [1] = high lane, [0] = low lane.
- data_o, output, 16: write data.
- rf_we, output, 1: register-file write enable.
- rf_regDest, output, 3: register-file destination.
- rf_dataIn, output, 16: register-file write data.
- rf_hb, output, 1: write the high byte.
- rf_lb, output, 1: write the low byte.
- busy_o, output, 1: stage occupied; stall upstream.
- done_o, output, 1: one-cycle completion pulse.
- err_o, output, 1: one-cycle error pulse, coincident with done_o.

Behaviour:
- Reset: state = IDLE, all operation registers cleared, every output 0. Reset asserted mid-access drops re_o/we_o immediately (asynchronous). No partial register-file write may occur.
- State IDLE:
  - start_i with load or store, and an aligned address: capture the operation, go to ACCESS.
  - start_i with a word access and op_addr_i[0]=1: no bus cycle; go to DONE with error flagged.
  - start_i with neither load nor store: go to DONE, no bus cycle, no error.
  - start_i low: stay in IDLE.
- State ACCESS:
  - addr_o = {addr[15:1],0}.
  - re_o=1 for a load; we_o=1 for a store.
  - be_o = 2'b11 for word accesses. For byte accesses, be_o = 2'b01 when addr[0]=0 and 2'b10 when addr[0]=1.
  - data_o = wdata for words; {wdata[7:0],wdata[7:0]} for bytes.
  - needWait_i=1: stay in ACCESS, increment the wait counter. When the counter reaches MAX_WAIT with needWait_i still high: drop strobes, go to DONE with error flagged, no register-file write.
  - needWait_i=0: latch data_i for loads, go to DONE.
- State DONE (exactly one cycle): done_o=1.
  - Successful load: rf_we=1, rf_regDest=dest.
  - Word load: rf_hb=rf_lb=1, rf_dataIn = latched data.
  - Byte load: rf_lb=1 only; rf_dataIn = {8'h00, selected lane}, where the lane is data[7:0] for addr[0]=0 and data[15:8] for addr[0]=1.
  - err_o=1 if the error was flagged. Always return to IDLE.
- busy_o = 1 in ACCESS and DONE, 0 in IDLE.
- start_i outside IDLE is ignored; no queueing.
- Latency: with no wait, start_i in cycle 0 gives ACCESS in cycle 1 and done_o in cycle 2. Each needWait_i cycle adds one cycle.
- Outside ACCESS: re_o, we_o, be_o are 0; addr_o and data_o hold their last values.
- Outside DONE: rf_we, rf_hb, rf_lb are 0.
- The wait counter clears on entry to ACCESS.

Decomposition:
- Package mem_pkg holds:
  - the state encoding (IDLE, ACCESS, DONE);
  - lane constants LANE_LO = 2'b01, LANE_HI = 2'b10, LANE_W = 2'b11;
  - the MAX_WAIT default.
- One natural sub-module, mem_lane: a combinational byte-lane steering block that generates be_o and data_o and extracts load data. The FSM and wait counter stay in mem_stage.

Test Plan:
- Word load, addr 0x0010, needWait_i=0, data_i=0xBEEF:
  - re_o high in cycle 1 with addr_o=0x0010, be_o=11;
  - cycle 2: done_o=1, rf_we=1, rf_dataIn=0xBEEF, rf_hb=rf_lb=1.
- Byte store, addr 0x0021, wdata 0x12A5, needWait_i high for 3 cycles:
  - we_o held 4 cycles, addr_o=0x0020, be_o=10, data_o=0xA5A5;
  - done_o in cycle 5, rf_we stays 0.
- Byte load, addr 0x0031, data_i=0x7F40: rf_dataIn=0x007F, rf_lb=1, rf_hb=0.
- Misaligned word store, addr 0x0041:
  - re_o/we_o never rise;
  - cycle 1: done_o=1, err_o=1.
- Timeout with MAX_WAIT=4 and needWait_i stuck high:
  - re_o drops after 4 wait cycles, then done_o=err_o=1, rf_we=0;
  - start_i pulsed mid-access is ignored.
- rst asserted during ACCESS: re_o, busy_o go to 0 immediately; after release the stage is in IDLE and a new load completes normally.
